// File: rtl/defs.sv
// Shared definitions for the execute-stage ALU: operation encoding, sequencer
// states and the default divider iteration count.
package defs;

    localparam int DIV_ITERS_DEFAULT = 32;

    typedef enum logic [4:0] {
        NO_OP, ADD, SUB, SLL, SRL, SRA, AND, OR, XOR,
        MUL, MULH, MULHSU, MULHU,
        LT, LTU, GE, GEU, EQ, NEQ,
        DIV, DIVU, REM, REMU
    } op_t;

    typedef enum logic {
        IDLE,
        DIVIDING
    } alu_state_t;

    function automatic logic isDivOp(input op_t op);
        return op inside {DIV, DIVU, REM, REMU};
    endfunction

endpackage

// File: rtl/alu_if.sv
// Operand bundle from decode plus the result/valid/busy return path of the ALU.
interface alu_if;
    import defs::*;

    logic        in_noop;
    op_t         in_op;
    logic [31:0] in_src1;
    logic [31:0] in_src2;
    logic        out_valid;
    logic [31:0] out_result;
    logic        busy;

    modport master (
        output in_noop, in_op, in_src1, in_src2,
        input  out_valid, out_result, busy
    );

    modport slave (
        input  in_noop, in_op, in_src1, in_src2,
        output out_valid, out_result, busy
    );

endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider: one quotient bit per cycle on operand magnitudes,
// with the sign fix-up folded into the combinational result on the last step.
module div_unit import defs::*; #(
    parameter int DIV_ITERS = DIV_ITERS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic        selRem_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        done_o,
    output logic [31:0] result_o
);

    localparam int CW = $clog2(DIV_ITERS);

    logic          run_q, run_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
    logic          negQ_q, negQ_d, negR_q, negR_d, selRem_q, selRem_d;
    logic [32:0]   remShift, trial;
    logic          lastIter;
    logic [31:0]   quoFinal, remFinal;

    always_comb begin
        run_d    = run_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        negQ_d   = negQ_q;
        negR_d   = negR_q;
        selRem_d = selRem_q;
        remShift = {rem_q, quo_q[31]};
        trial    = remShift - {1'b0, dvsr_q};
        lastIter = run_q && (cnt_q == CW'(DIV_ITERS - 1));
        if (start_i) begin
            run_d    = 1'b1;
            cnt_d    = '0;
            rem_d    = '0;
            quo_d    = (signed_i && dividend_i[31]) ? -dividend_i : dividend_i;
            dvsr_d   = (signed_i && divisor_i[31]) ? -divisor_i : divisor_i;
            negQ_d   = signed_i & (dividend_i[31] ^ divisor_i[31]);
            negR_d   = signed_i & dividend_i[31];
            selRem_d = selRem_i;
        end else if (run_q) begin
            // A borrow out of the trial subtraction means restore (keep the shifted value)
            rem_d = trial[32] ? remShift[31:0] : trial[31:0];
            quo_d = {quo_q[30:0], ~trial[32]};
            cnt_d = cnt_q + CW'(1);
            run_d = !lastIter;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            negQ_q   <= 1'b0;
            negR_q   <= 1'b0;
            selRem_q <= 1'b0;
        end else begin
            run_q    <= run_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            negQ_q   <= negQ_d;
            negR_q   <= negR_d;
            selRem_q <= selRem_d;
        end
    end

    assign quoFinal = negQ_q ? -quo_d : quo_d;
    assign remFinal = negR_q ? -rem_d : rem_d;
    assign result_o = selRem_q ? remFinal : quoFinal;
    assign done_o   = lastIter;

endmodule

// File: rtl/alu.sv
// Execute-stage ALU: single-cycle arithmetic/logic/compare/multiply datapath plus
// the IDLE/DIVIDING sequencing around the iterative divider.
module alu import defs::*; #(
    parameter int DIV_ITERS = DIV_ITERS_DEFAULT
) (
    input  logic  clk,
    input  logic  rst_n,
    alu_if.slave  bus
);

    alu_state_t         state_q, state_d;
    logic               valid_q, valid_d, busy_q, busy_d;
    logic [31:0]        result_q, result_d, aluRes, divResult;
    logic               accept, divSigned, divRem, divByZero, divOverflow, divStart, divDone;
    logic [4:0]         shamt;
    logic signed [32:0] mulA, mulB;
    logic signed [65:0] prod;
    logic               unusedProdTop;

    assign accept      = (state_q == IDLE) && !bus.in_noop && (bus.in_op != NO_OP);
    assign divSigned   = bus.in_op inside {DIV, REM};
    assign divRem      = bus.in_op inside {REM, REMU};
    assign divByZero   = (bus.in_src2 == 32'd0);
    assign divOverflow = divSigned && (bus.in_src1 == 32'h8000_0000) && (bus.in_src2 == 32'hFFFF_FFFF);
    assign divStart    = accept && isDivOp(bus.in_op) && !divByZero && !divOverflow;

    // One 33x33 signed multiplier serves all four multiply flavours via operand extension
    assign shamt         = bus.in_src2[4:0];
    assign mulA          = {(bus.in_op inside {MULH, MULHSU}) & bus.in_src1[31], bus.in_src1};
    assign mulB          = {(bus.in_op == MULH) & bus.in_src2[31], bus.in_src2};
    assign prod          = 66'(mulA) * 66'(mulB);
    assign unusedProdTop = ^prod[65:64];

    always_comb begin
        aluRes = 32'd0;
        case (bus.in_op)
            ADD:    aluRes = bus.in_src1 + bus.in_src2;
            SUB:    aluRes = bus.in_src1 - bus.in_src2;
            SLL:    aluRes = bus.in_src1 << shamt;
            SRL:    aluRes = bus.in_src1 >> shamt;
            SRA:    aluRes = $signed(bus.in_src1) >>> shamt;
            AND:    aluRes = bus.in_src1 & bus.in_src2;
            OR:     aluRes = bus.in_src1 | bus.in_src2;
            XOR:    aluRes = bus.in_src1 ^ bus.in_src2;
            MUL:    aluRes = prod[31:0];
            MULH, MULHSU, MULHU: aluRes = prod[63:32];
            LT:     aluRes = {31'd0, $signed(bus.in_src1) < $signed(bus.in_src2)};
            LTU:    aluRes = {31'd0, bus.in_src1 < bus.in_src2};
            GE:     aluRes = {31'd0, $signed(bus.in_src1) >= $signed(bus.in_src2)};
            GEU:    aluRes = {31'd0, bus.in_src1 >= bus.in_src2};
            EQ:     aluRes = {31'd0, bus.in_src1 == bus.in_src2};
            NEQ:    aluRes = {31'd0, bus.in_src1 != bus.in_src2};
            DIV, DIVU: aluRes = divByZero ? 32'hFFFF_FFFF : 32'h8000_0000;
            REM, REMU: aluRes = divByZero ? bus.in_src1 : 32'd0;
            default: aluRes = 32'd0;
        endcase
    end

    div_unit #(.DIV_ITERS(DIV_ITERS)) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (divStart),
        .signed_i   (divSigned),
        .selRem_i   (divRem),
        .dividend_i (bus.in_src1),
        .divisor_i  (bus.in_src2),
        .done_o     (divDone),
        .result_o   (divResult)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            result_q <= 32'd0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (divStart) state_d = DIVIDING;
            DIVIDING: if (divDone)  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Inputs are ignored while dividing, including on the completing edge
    always_comb begin
        valid_d  = 1'b0;
        result_d = 32'd0;
        busy_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (divStart) begin
                    busy_d = 1'b1;
                end else if (accept) begin
                    valid_d  = 1'b1;
                    result_d = aluRes;
                end
            end
            DIVIDING: begin
                if (divDone) begin
                    valid_d  = 1'b1;
                    result_d = divResult;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.out_valid  = valid_q;
    assign bus.out_result = result_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu: single-cycle ops, divider timing,
// divide special cases and reset abort of an in-flight division.
module tb_alu;
    import defs::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    int   busyLen;
    logic sawValid;

    alu_if bus();

    alu #(.DIV_ITERS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic noop, input op_t op, input logic [31:0] a, input logic [31:0] b);
        bus.in_noop = noop;
        bus.in_op   = op;
        bus.in_src1 = a;
        bus.in_src2 = b;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
            $error("[TB] comparison %s did not match", tag);
        end
    endtask

    // Counts consecutive sampled cycles with busy high, bounded so a stuck divider ends the wait
    task automatic waitBusyRun(output int n, output logic saw);
        n = 0;
        saw = 1'b0;
        while (bus.busy === 1'b1 && n < 40) begin
            if (bus.out_valid !== 1'b0) saw = 1'b1;
            n++;
            tick();
        end
    endtask

    task automatic checkSingle(input string tag, input logic [31:0] expected);
        checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        checkOutput({tag, "_result"}, bus.out_result, expected);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b1, NO_OP, 32'd0, 32'd0);
        tick();
        tick();
        checkOutput("reset_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_result", bus.out_result, 32'd0);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;

        applyStimulus(1'b0, ADD, 32'd5, 32'hFFFF_FFFD);
        tick();
        checkSingle("add", 32'd2);
        applyStimulus(1'b0, SRA, 32'h8000_0000, 32'd4);
        tick();
        checkSingle("sra", 32'hF800_0000);
        applyStimulus(1'b1, ADD, 32'd7, 32'd7);
        tick();
        checkOutput("noop_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("noop_result", bus.out_result, 32'd0);
        applyStimulus(1'b0, NO_OP, 32'd7, 32'd7);
        tick();
        checkOutput("no_op_valid", 32'(bus.out_valid), 32'd0);

        applyStimulus(1'b0, MULH, 32'h8000_0000, 32'h8000_0000);
        tick();
        checkSingle("mulh", 32'h4000_0000);
        applyStimulus(1'b0, MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        checkSingle("mulhu", 32'hFFFF_FFFE);
        applyStimulus(1'b0, MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        checkSingle("mul", 32'd1);
        applyStimulus(1'b0, MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        checkSingle("mulhsu", 32'hFFFF_FFFF);
        applyStimulus(1'b0, SLL, 32'd1, 32'h0000_0023);
        tick();
        checkSingle("sll_shamt", 32'd8);
        applyStimulus(1'b0, LT, 32'hFFFF_FFFF, 32'd1);
        tick();
        checkSingle("lt", 32'd1);
        applyStimulus(1'b0, LTU, 32'hFFFF_FFFF, 32'd1);
        tick();
        checkSingle("ltu", 32'd0);
        applyStimulus(1'b0, SUB, 32'd0, 32'd1);
        tick();
        checkSingle("sub_wrap", 32'hFFFF_FFFF);

        applyStimulus(1'b0, DIV, 32'hFFFF_FFF9, 32'd2);
        tick();
        applyStimulus(1'b0, ADD, 32'd1, 32'd1);
        waitBusyRun(busyLen, sawValid);
        checkOutput("div_busy_len", busyLen, 32'd32);
        checkOutput("div_valid_while_busy", 32'(sawValid), 32'd0);
        checkSingle("div", 32'hFFFF_FFFD);

        applyStimulus(1'b0, REM, 32'hFFFF_FFF9, 32'd2);
        tick();
        checkOutput("rem_accepted_busy", 32'(bus.busy), 32'd1);
        applyStimulus(1'b0, ADD, 32'd1, 32'd1);
        waitBusyRun(busyLen, sawValid);
        checkOutput("rem_busy_len", busyLen, 32'd32);
        checkOutput("rem_valid_while_busy", 32'(sawValid), 32'd0);
        checkSingle("rem", 32'hFFFF_FFFF);

        applyStimulus(1'b0, DIVU, 32'd9, 32'd0);
        tick();
        checkSingle("divu_by_zero", 32'hFFFF_FFFF);
        applyStimulus(1'b0, REM, 32'd9, 32'd0);
        tick();
        checkSingle("rem_by_zero", 32'd9);
        applyStimulus(1'b0, DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        tick();
        checkSingle("div_overflow", 32'h8000_0000);
        applyStimulus(1'b0, REM, 32'h8000_0000, 32'hFFFF_FFFF);
        tick();
        checkSingle("rem_overflow", 32'd0);

        applyStimulus(1'b0, DIVU, 32'd100, 32'd7);
        tick();
        checkOutput("divu_started_busy", 32'(bus.busy), 32'd1);
        applyStimulus(1'b1, NO_OP, 32'd0, 32'd0);
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("abort_result", bus.out_result, 32'd0);
        tick();
        rst_n = 1'b1;
        sawValid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) sawValid = 1'b1;
        end
        checkOutput("abort_no_stale", 32'(sawValid), 32'd0);
        applyStimulus(1'b0, ADD, 32'd1, 32'd1);
        tick();
        checkSingle("add_after_reset", 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu.md
# alu

Execute-stage arithmetic unit of the RISC-V core. It consumes the registered `noop`/`op`/`src1`/`src2` bundle produced by the decode/operand-select stage and returns a 32-bit result with a valid flag. Add, logic, shift, compare and multiply operations complete in one cycle. DIV/DIVU/REM/REMU run on an iterative restoring divider, and `busy` stalls the upstream stage while a division is in progress.

## Interface
- `DIV_ITERS`, 32: divider iterations per division; must equal the data width.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `in_noop`  in  1  bubble; the bundle is ignored when high.
- `in_op`  in  op_t  operation selector from the shared package.
- `in_src1`  in  32  operand 1, signed.
- `in_src2`  in  32  operand 2, signed; shift amount uses [4:0].
- `out_valid`  out  1  `out_result` holds a completed operation this cycle.
- `out_result`  out  32  result.
- `busy`  out  1  registered; divider occupied, so upstream must hold its bundle.

## Operation
- States: IDLE and DIVIDING.
- IDLE with `in_noop`=1 or `in_op`=NO_OP:
  - Next cycle `out_valid`=0 and `out_result`=0.
- IDLE with a single-cycle op:
  - Next cycle `out_valid`=1 and `out_result` holds the result.
- Single-cycle op results:
  - ADD/SUB: modulo 2^32.
  - SLL/SRL/SRA: shift by `in_src2[4:0]`; SRA is arithmetic.
  - AND/OR/XOR: bitwise.
  - MUL: low 32 bits of the product. MULH is signed×signed, MULHSU is signed×unsigned, MULHU is unsigned×unsigned; each returns the high 32 bits of the 64-bit product.
  - LT/LTU/GE/GEU/EQ/NEQ: result is 32'd1 if true, else 32'd0. LT/GE are signed; LTU/GEU are unsigned.
- IDLE with a divide op and divisor ≠ 0, excluding the signed-overflow case:
  - Latch `|src1|`, `|src2|` (raw values for DIVU/REMU), the quotient sign (src1[31]^src2[31]) and the remainder sign (src1[31]). Signs apply to DIV/REM only.
  - Counter := 0; go to DIVIDING; `busy`:=1; `out_valid`:=0.
- Divide special cases complete in a single cycle, with no busy:
  - Divisor 0: quotient = 0xFFFFFFFF and remainder = src1, for both signed and unsigned ops.
  - DIV/REM with src1=0x80000000 and src2=0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- DIVIDING: one restoring iteration per cycle (shift the remainder:dividend pair left, trial-subtract the divisor, set the quotient bit); counter increments.
  - `out_valid`=0 throughout.
  - All inputs are ignored throughout.
- On the edge that completes iteration `DIV_ITERS`:
  - Apply sign correction; select the quotient (DIV/DIVU) or remainder (REM/REMU).
  - Register it to `out_result` with `out_valid`:=1 and `busy`:=0; return to IDLE.
- Inputs present during that final edge are not accepted. Upstream presents the next bundle in the cycle `busy` falls.

## Timing
- Reset values: `out_valid`=0, `out_result`=0, `busy`=0, state IDLE, counter 0, divider registers 0.
- Single-cycle ops: latency 1, throughput 1 per cycle.
- Division: accepted at edge E. `busy` is high after E through E+`DIV_ITERS`-1, and `out_valid`=1 after edge E+`DIV_ITERS`.
- Back-to-back divisions: the second bundle is accepted at E+`DIV_ITERS`+1 at the earliest.
- Reset asserted mid-division aborts it immediately: all outputs and state return to reset values, and no result is produced.
- `busy` is never high in the same cycle as `out_valid`=1 for a division result.

## Structure
- `op_t` (all enumerators including DIV/DIVU/REM/REMU) lives in the shared `defs` package, together with the `DIV_ITERS` default constant.
- Sub-module `div_unit`: the iterative restoring divider with start/done handshake, operand magnitudes and sign fix-up. `alu` owns the IDLE/DIVIDING sequencing, the single-cycle datapath and the output registers.

## Test plan
- ADD 5, -3, then SRA 0x80000000 by 4, on consecutive cycles:
  - results 2 then 0xF8000000, one cycle apart, `out_valid`=1 both.
- MULH 0x80000000, 0x80000000:
  - result 0x40000000.
- MULHU 0xFFFFFFFF, 0xFFFFFFFF:
  - result 0xFFFFFFFE.
- DIV -7, 2:
  - `busy` high for 32 cycles.
  - Then result 0xFFFFFFFD with `out_valid`=1.
- REM -7, 2 issued in the cycle `busy` falls:
  - accepted; result 0xFFFFFFFF 32 cycles later.
- Single-cycle divide special cases, with `busy` staying 0:
  - DIVU 9, 0 → 0xFFFFFFFF next cycle.
  - REM 9, 0 → 9.
  - DIV 0x80000000, -1 → 0x80000000.
  - REM 0x80000000, -1 → 0.
- Assert `rst_n` low during iteration 10 of a DIVU:
  - `busy`=0 and `out_valid`=0 immediately; no stale result appears.
  - After release, ADD 1, 1 → 2 next cycle.
